// File: rtl/bus_mem_pkg.sv
// Shared definitions for the bus memory responder.
// Contents: responder state encoding, CPU read/write direction encoding,
// and the bus word width.
package bus_mem_pkg;

  localparam int WORD_W = 32;

  // Encoding is visible on state_o, so the values are fixed.
  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/mem_array.sv
// Word-addressed storage for the responder: DEPTH x DATA_W words,
// one synchronous write port and one asynchronous read port.
// Ports:
//   i_clock  system clock
//   i_we     write enable (sampled at posedge)
//   i_waddr  write word index
//   i_wdata  write data
//   i_raddr  read word index
//   o_rdata  read data, combinational from i_raddr
module mem_array #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_W    = 32
) (
  input  logic                 i_clock,
  input  logic                 i_we,
  input  logic [ADDR_BITS-1:0] i_waddr,
  input  logic [DATA_W-1:0]    i_wdata,
  input  logic [ADDR_BITS-1:0] i_raddr,
  output logic [DATA_W-1:0]    o_rdata
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clock) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // A read of the word being written shows the old contents until the edge.
  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/bus_memory_responder.sv
// Memory-side responder for the CPU word bus. After reset it zero-clears
// its RAM (optional), accepts a program image over a valid/ready stream,
// then releases the CPU and serves its reads and writes. One word address
// (IO_ADDR) is an output register with a write strobe.
//
// Load stream handshake: a word is transferred on a posedge where
// load_valid and load_ready are both 1; load_ready depends only on the
// registered state, never on load_valid.
//
// Ports:
//   clock, reset          system clock; synchronous active-low reset
//   cpu_address/datao/rw  CPU word bus request (rw: 1 read, 0 write)
//   cpu_data              read data, combinational from cpu_address
//   cpu_reset             holds the CPU in reset until RUN
//   load_valid/ready/data/last  program image stream
//   io_out, io_strobe     output register and its per-write pulse
//   err                   sticky out-of-range access flag
//   state_o               current state (0 CLEAR, 1 LOAD, 2 RUN)
module bus_memory_responder
  import bus_mem_pkg::*;
#(
  parameter int          ADDR_BITS      = 8,
  parameter bit          CLEAR_ON_RESET = 1'b1,
  parameter logic [31:0] IO_ADDR        = 32'hFFFF_FFFF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [WORD_W-1:0] cpu_address,
  input  logic [WORD_W-1:0] cpu_datao,
  input  logic              cpu_rw,
  output logic [WORD_W-1:0] cpu_data,
  output logic              cpu_reset,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [WORD_W-1:0] load_data,
  input  logic              load_last,
  output logic [WORD_W-1:0] io_out,
  output logic              io_strobe,
  output logic              err,
  output logic [1:0]        state_o
);

  localparam logic [ADDR_BITS-1:0] LAST_IDX = '1;
  localparam logic [ADDR_BITS-1:0] IDX_ONE  = 1;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_BITS-1:0]  r_clr_idx;
  logic [ADDR_BITS-1:0]  r_load_ptr;
  logic [WORD_W-1:0]     r_io_out;
  logic                  r_io_strobe;
  logic                  r_err;

  logic                  w_load_ready;
  logic                  w_run;
  logic                  w_in_ram;
  logic                  w_is_io;
  logic                  w_cpu_wr;
  logic                  w_load_fire;
  logic                  w_mem_we;
  logic [ADDR_BITS-1:0]  w_mem_waddr;
  logic [WORD_W-1:0]     w_mem_wdata;
  logic [WORD_W-1:0]     w_mem_rdata;
  logic [WORD_W-1:0]     w_cpu_data;

  // Address decode: RAM window is [0, DEPTH); everything else except
  // IO_ADDR is out of range.
  assign w_run       = (r_state == ST_RUN);
  assign w_in_ram    = ((cpu_address >> ADDR_BITS) == '0);
  assign w_is_io     = (cpu_address == IO_ADDR);
  assign w_cpu_wr    = w_run && (cpu_rw == RW_WRITE);
  assign w_load_fire = reset && (r_state == ST_LOAD) && load_valid;

  // ---------------- FSM ----------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= CLEAR_ON_RESET ? ST_CLEAR : ST_LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_load_ready = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        if (r_clr_idx == LAST_IDX) begin
          w_state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_load_ready = 1'b1;
        // A full image ends the load even without load_last.
        if (load_valid && (load_last || (r_load_ptr == LAST_IDX))) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        w_state_nxt = ST_RUN;
      end
      default: begin
        w_state_nxt = ST_LOAD;
      end
    endcase
  end

  // ---------------- clear / load pointers ----------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_clr_idx  <= '0;
      r_load_ptr <= '0;
    end else begin
      if (r_state == ST_CLEAR) begin
        r_clr_idx <= r_clr_idx + IDX_ONE;
      end
      if (w_load_fire) begin
        r_load_ptr <= r_load_ptr + IDX_ONE;
      end
    end
  end

  // ---------------- RAM write-port mux ----------------
  // CLEAR and LOAD own the port; CPU writes only reach it in RUN.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_waddr = r_clr_idx;
    w_mem_wdata = '0;
    if (reset) begin
      case (r_state)
        ST_CLEAR: begin
          w_mem_we = 1'b1;
        end
        ST_LOAD: begin
          w_mem_we    = load_valid;
          w_mem_waddr = r_load_ptr;
          w_mem_wdata = load_data;
        end
        ST_RUN: begin
          w_mem_we    = w_cpu_wr && w_in_ram;
          w_mem_waddr = cpu_address[ADDR_BITS-1:0];
          w_mem_wdata = cpu_datao;
        end
        default: begin
          w_mem_we = 1'b0;
        end
      endcase
    end
  end

  mem_array #(
    .ADDR_BITS (ADDR_BITS),
    .DATA_W    (WORD_W)
  ) u_mem (
    .i_clock (clock),
    .i_we    (w_mem_we),
    .i_waddr (w_mem_waddr),
    .i_wdata (w_mem_wdata),
    .i_raddr (cpu_address[ADDR_BITS-1:0]),
    .o_rdata (w_mem_rdata)
  );

  // ---------------- IO register and error flag ----------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_io_out    <= '0;
      r_io_strobe <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_io_strobe <= w_cpu_wr && w_is_io;
      if (w_cpu_wr && w_is_io) begin
        r_io_out <= cpu_datao;
      end
      if (w_run && !w_in_ram && !w_is_io) begin
        r_err <= 1'b1;
      end
    end
  end

  // ---------------- CPU read path ----------------
  always_comb begin
    w_cpu_data = '0;
    if (w_run) begin
      if (w_in_ram) begin
        w_cpu_data = w_mem_rdata;
      end else if (w_is_io) begin
        w_cpu_data = r_io_out;
      end
    end
  end

  assign cpu_data   = w_cpu_data;
  assign cpu_reset  = !w_run;
  assign load_ready = w_load_ready;
  assign io_out     = r_io_out;
  assign io_strobe  = r_io_strobe;
  assign err        = r_err;
  assign state_o    = r_state;

endmodule

// File: tb/tb_bus_memory_responder.sv
// Directed bench for bus_memory_responder with ADDR_BITS=4 (16 words).
module tb_bus_memory_responder;

  localparam int          AB    = 4;
  localparam int          DEPTH = 16;
  localparam logic [31:0] IO    = 32'hFFFF_FFFF;

  // ---------------- clock / reset / DUT ----------------
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] cpu_address = '0;
  logic [31:0] cpu_datao = '0;
  logic        cpu_rw = 1'b1;
  logic        load_valid = 1'b0;
  logic [31:0] load_data = '0;
  logic        load_last = 1'b0;
  logic [31:0] cpu_data;
  logic        cpu_reset;
  logic        load_ready;
  logic [31:0] io_out;
  logic        io_strobe;
  logic        err;
  logic [1:0]  state_o;

  always #5 clock = ~clock;

  bus_memory_responder #(
    .ADDR_BITS      (AB),
    .CLEAR_ON_RESET (1'b1),
    .IO_ADDR        (IO)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .cpu_address (cpu_address),
    .cpu_datao   (cpu_datao),
    .cpu_rw      (cpu_rw),
    .cpu_data    (cpu_data),
    .cpu_reset   (cpu_reset),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_data   (load_data),
    .load_last   (load_last),
    .io_out      (io_out),
    .io_strobe   (io_strobe),
    .err         (err),
    .state_o     (state_o)
  );

  // ---------------- scoreboard counters ----------------
  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 clearing, 1 loading, 2 running. Counts are words done so far.
  int          m_phase = 0;
  int          m_clr = 0;
  int          m_ld = 0;
  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_io = '0;
  logic        m_strobe = 1'b0;
  logic        m_err = 1'b0;

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    forever begin
      @(posedge clock);
      if (!reset) begin
        m_phase  = 0;
        m_clr    = 0;
        m_ld     = 0;
        m_io     = '0;
        m_strobe = 1'b0;
        m_err    = 1'b0;
      end else begin
        m_strobe = 1'b0;
        if (m_phase == 0) begin
          m_mem[m_clr] = '0;
          m_clr++;
          if (m_clr == DEPTH) m_phase = 1;
        end else if (m_phase == 1) begin
          if (load_valid) begin
            m_mem[m_ld] = load_data;
            m_ld++;
            if (load_last || m_ld == DEPTH) m_phase = 2;
          end
        end else begin
          if (cpu_address < DEPTH) begin
            if (!cpu_rw) m_mem[cpu_address[AB-1:0]] = cpu_datao;
          end else if (cpu_address == IO) begin
            if (!cpu_rw) begin
              m_io     = cpu_datao;
              m_strobe = 1'b1;
            end
          end else begin
            m_err = 1'b1;
          end
        end
      end
    end
  end

  function automatic logic [31:0] model_rd();
    if (m_phase != 2) return '0;
    if (cpu_address < DEPTH) return m_mem[cpu_address[AB-1:0]];
    if (cpu_address == IO) return m_io;
    return '0;
  endfunction

  // Every-cycle compare against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clock);
      if (chk_en) begin
        cmp("m_state", 32'(state_o), m_phase[31:0]);
        cmp("m_cpu_reset", 32'(cpu_reset), 32'(m_phase != 2));
        cmp("m_load_ready", 32'(load_ready), 32'(m_phase == 1));
        cmp("m_cpu_data", cpu_data, model_rd());
        cmp("m_io_out", io_out, m_io);
        cmp("m_io_strobe", 32'(io_strobe), 32'(m_strobe));
        cmp("m_err", 32'(err), 32'(m_err));
      end
    end
  end

  // ---------------- driver tasks (all return at posedge+1) ----------------
  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b0;
    load_valid = 1'b0;
    load_last = 1'b0;
    cpu_rw = 1'b1;
    cpu_address = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
  endtask

  task automatic wait_ready(input string name);
    for (int i = 0; i < 40; i++) begin
      if (load_ready) break;
      @(negedge clock);
    end
    cmp(name, 32'(load_ready), 32'd1);
    @(posedge clock); #1;
  endtask

  task automatic load_word(input logic [31:0] d, input logic last);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    @(posedge clock); #1;
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic cpu_read(input logic [31:0] a, input logic [31:0] exp, input string name);
    cpu_rw = 1'b1;
    cpu_address = a;
    #1 cmp(name, cpu_data, exp);
    @(posedge clock); #1;
  endtask

  task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
    cpu_rw = 1'b0;
    cpu_address = a;
    cpu_datao = d;
    @(posedge clock); #1;
    cpu_rw = 1'b1;
    cpu_address = '0;
  endtask

  // ---------------- directed sequence ----------------
  int clr_cycles;

  initial begin
    // Reset low for two posedges, then count CLEAR cycles.
    @(posedge clock); #1 chk_en = 1'b1;
    @(posedge clock); #1 reset = 1'b1;
    clr_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (state_o == 2'd0) clr_cycles++;
      else break;
    end
    cmp("clear_len", clr_cycles, 32'd16);
    cmp("ready_after_clear", 32'(load_ready), 32'd1);
    @(posedge clock); #1;

    // Short image with a valid gap.
    load_word(32'h11, 1'b0);
    load_word(32'h22, 1'b0);
    @(posedge clock); #1;
    load_word(32'h33, 1'b1);
    cmp("run_entered", 32'(state_o), 32'd2);
    cmp("cpu_released", 32'(cpu_reset), 32'd0);
    cpu_read(32'd0, 32'h11, "rd0");
    cpu_read(32'd1, 32'h22, "rd1");
    cpu_read(32'd2, 32'h33, "rd2");
    cpu_read(32'd3, 32'h0,  "rd3_cleared");

    // RAM write then read back.
    cpu_write(32'd5, 32'hDEAD_BEEF);
    cpu_read(32'd5, 32'hDEAD_BEEF, "rd5");
    cmp("err_clean", 32'(err), 32'd0);

    // Same-address write: old word until the edge, new word after.
    cpu_rw = 1'b0; cpu_address = 32'd7; cpu_datao = 32'h7777_0007;
    #1 cmp("raw_old", cpu_data, 32'h0);
    @(posedge clock); #1;
    cmp("raw_new", cpu_data, 32'h7777_0007);
    cpu_rw = 1'b1; cpu_address = '0;
    @(posedge clock); #1;

    // IO register.
    cpu_write(IO, 32'h0000_00A5);
    cmp("io_out", io_out, 32'hA5);
    cmp("io_strobe_hi", 32'(io_strobe), 32'd1);
    @(posedge clock); #1;
    cmp("io_strobe_lo", 32'(io_strobe), 32'd0);
    cpu_read(IO, 32'hA5, "rd_io");

    // Back-to-back IO writes keep the strobe high.
    cpu_rw = 1'b0; cpu_address = IO; cpu_datao = 32'h1;
    @(posedge clock); #1;
    cmp("io_b2b_1", 32'(io_strobe), 32'd1);
    cpu_datao = 32'h2;
    @(posedge clock); #1;
    cmp("io_b2b_2", 32'(io_strobe), 32'd1);
    cmp("io_b2b_val", io_out, 32'h2);
    cpu_rw = 1'b1; cpu_address = '0;
    @(posedge clock); #1;
    cmp("io_b2b_end", 32'(io_strobe), 32'd0);

    // Out-of-range access.
    cpu_read(32'h100, 32'h0, "rd_oor");
    cmp("err_set", 32'(err), 32'd1);
    cpu_write(32'h100, 32'h1234_5678);
    cpu_read(32'd0, 32'h11, "oor_no_alias");
    cmp("err_sticky", 32'(err), 32'd1);

    // Reset from RUN: CLEAR repeats and old contents vanish.
    do_reset();
    cmp("rst_io", io_out, 32'h0);
    cmp("rst_err", 32'(err), 32'd0);
    wait_ready("ready_2");
    load_word(32'h77, 1'b1);
    cpu_read(32'd0, 32'h77, "re_rd0");
    cpu_read(32'd1, 32'h0,  "re_rd1_cleared");
    cpu_read(32'd5, 32'h0,  "re_rd5_cleared");

    // Reset mid-load, then a full 16-word image without load_last.
    do_reset();
    wait_ready("ready_3");
    load_word(32'hAAA, 1'b0);
    load_word(32'hBBB, 1'b0);
    do_reset();
    cmp("midload_clear", 32'(state_o), 32'd0);
    wait_ready("ready_4");
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) cmp("still_loading", 32'(state_o), 32'd1);
      load_word(32'h1000 + 32'(i * 3), 1'b0);
    end
    cmp("full_image_run", 32'(state_o), 32'd2);
    cmp("full_io", io_out, 32'h0);
    cmp("full_err", 32'(err), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      cpu_read(32'(i), 32'h1000 + 32'(i * 3), "full_rd");
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bus_memory_responder.md
Name: bus_memory_responder

Overview:
- Memory-side responder for the CPU's word bus (address, write data, rw, read data).
- Holds a word-addressed program/data RAM, zero-clears it after reset, then accepts a program image over a valid/ready load stream.
- After loading it releases the CPU and serves its reads and writes.
- One address is a memory-mapped output register.

Parameters:
- ADDR_BITS, 8, RAM index width; DEPTH = 2**ADDR_BITS words of 32 bits.
- CLEAR_ON_RESET, 1, 1 = run CLEAR state after reset; 0 = go straight to LOAD.
- IO_ADDR, 32'hFFFF_FFFF, word address of the output register.

Ports:
- clock  in  1  single system clock; all state updates on posedge.
- reset  in  1  synchronous, active-low reset.
- cpu_address  in  32  word address driven by CPU.
- cpu_datao  in  32  CPU write data.
- cpu_rw  in  1  1 = read, 0 = write.
- cpu_data  out  32  read data to CPU, combinational from cpu_address.
- cpu_reset  out  1  active-high hold to CPU reset; 1 until RUN.
- load_valid  in  1  load word present.
- load_ready  out  1  responder accepts a load word this cycle.
- load_data  in  32  program word.
- load_last  in  1  marks final word of the image.
- io_out  out  32  output register contents.
- io_strobe  out  1  one-cycle pulse on each write to IO_ADDR.
- err  out  1  sticky out-of-range access flag.
- state_o  out  2  current state: 0 CLEAR, 1 LOAD, 2 RUN.

Behaviour:
- Reset (reset==0 at posedge):
  - state = CLEAR if CLEAR_ON_RESET, else LOAD.
  - clr_idx = 0, load_ptr = 0, io_out = 0, io_strobe = 0, err = 0.
  - Applies from any state, including mid-CLEAR or mid-LOAD; a partial load is abandoned.
- CLEAR:
  - Each cycle writes 0 to ram[clr_idx], then clr_idx increments.
  - When clr_idx == DEPTH-1 is written, go to LOAD next cycle. CLEAR therefore lasts exactly DEPTH cycles.
  - load_ready = 0.
- LOAD:
  - load_ready = 1.
  - Transfer occurs when load_valid && load_ready at posedge: ram[load_ptr] = load_data, then load_ptr increments.
  - Go to RUN after the transfer if load_last == 1 or load_ptr == DEPTH-1. On a full image, the last word is taken even without load_last.
  - load_valid low: hold state, no write.
- RUN:
  - load_ready = 0. RUN is left only via reset.
- cpu_reset = (state != RUN). It is decoded from registered state, so it goes low in the first cycle of RUN.
- CPU reads (combinational, zero latency; the CPU samples mid-cycle):
  - cpu_data = ram[cpu_address[ADDR_BITS-1:0]] when cpu_address < DEPTH.
  - cpu_data = io_out when cpu_address == IO_ADDR.
  - cpu_data = 0 otherwise, and 0 in every non-RUN state.
- CPU writes (RUN and cpu_rw == 0, at posedge):
  - cpu_address < DEPTH: ram updated with cpu_datao.
  - cpu_address == IO_ADDR: io_out = cpu_datao; io_strobe = 1 for the following cycle only.
  - Otherwise: no write.
- err:
  - Set at posedge in RUN when cpu_address >= DEPTH and != IO_ADDR, for a read or a write.
  - Cleared only by reset.
- Writes in CLEAR/LOAD from the CPU side are ignored. CLEAR/LOAD own the RAM write port exclusively.
- Read and write to the same address in RUN: cpu_data shows the old word until the posedge, then the new word.
- Consecutive IO writes give one strobe per write cycle. A continuous write on IO_ADDR holds io_strobe high.

Decomposition:
- Shared package bus_mem_pkg:
  - state encoding CLEAR=0, LOAD=1, RUN=2.
  - RW_READ=1, RW_WRITE=0.
  - 32-bit word width constant.
- One sub-module, mem_array: DEPTH x 32 storage, async read port, single sync write port (we, waddr, wdata).
- Top-level block holds the FSM, the write-port mux (clear / load / cpu), address decode, io_out and err.

Test Plan:
- ADDR_BITS=4, reset low 2 cycles then high -> state_o=0 for exactly 16 cycles, then load_ready=1; cpu_data=0 and cpu_reset=1 throughout.
- LOAD of 0x11, 0x22, 0x33 with load_last on 0x33 and a one-cycle load_valid gap after 0x22 -> RUN next cycle, cpu_reset=0; reads at address 0/1/2/3 return 0x11/0x22/0x33/0.
- RUN, rw=0, address 5, data 0xDEADBEEF; next cycle rw=1, address 5 -> cpu_data=0xDEADBEEF; err stays 0.
- Write 0x000000A5 to 0xFFFFFFFF -> io_out=0xA5, io_strobe high one cycle; read of 0xFFFFFFFF returns 0xA5.
- Read of address 0x100 with ADDR_BITS=4 -> cpu_data=0, err=1 and stays 1; a write there leaves RAM unchanged.
- Reset asserted after 2 load words, then re-load 16 words without load_last -> CLEAR repeats, words at 0/1 read 0 before re-load; RUN entered after the 16th word; io_out=0, err=0.
